regfile_wb_arbiter: RTL

Writeback arbiter for the two-write-port integer register file: the normal port (`rd`/`write_data`) and the atomic port (`atomic_rd`/`atomic_write_data`). It takes results from three producers (ALU, load unit, atomic unit) over valid/ready handshakes and grants up to two writes per cycle. It never issues two same-cycle writes to the same register, so the register file's same-`rd` write suppression never triggers. Outputs are registered and drive the register-file write ports directly.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/regfile_wb_arbiter_if.sv | 52 +++++
 rtl/regfile_wb_arbiter_port_grant.sv | 65 ++++++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file writeback path.
// Holds widths, producer indices, the writeback request struct and a
// small helper that turns a destination register into a one-hot mask.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int NUM_WB = 3;

  typedef logic [1:0] wb_idx_t;

  localparam wb_idx_t WB_ALU = 2'd0;
  localparam wb_idx_t WB_LSU = 2'd1;
  localparam wb_idx_t WB_AMO = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // One-hot of rd when en is set; x0 never appears in the mask.
  function automatic logic [31:0] rd_onehot(input logic en, input logic [AW-1:0] rd);
    logic [31:0] m;
    m = '0;
    if (en && (rd != '0)) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer handshakes plus the two register-file write ports.
// The arbiter side is the slave modport; producers and the regfile use master.
// No clock in here: clk/reset stay plain ports on the arbiter.
interface regfile_wb_arbiter_if;
  import cpu_pkg::*;

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            amo_valid;
  logic [AW-1:0]   amo_rd;
  logic [XLEN-1:0] amo_data;
  logic            amo_ready;

  logic            wr_en;
  logic [AW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;

  logic            awr_en;
  logic [AW-1:0]   awr_rd;
  logic [XLEN-1:0] awr_data;

  logic [31:0]     pending_mask;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  amo_valid, amo_rd, amo_data,
    output alu_ready, lsu_ready, amo_ready,
    output wr_en, wr_rd, wr_data,
    output awr_en, awr_rd, awr_data,
    output pending_mask
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output amo_valid, amo_rd, amo_data,
    input  alu_ready, lsu_ready, amo_ready,
    input  wr_en, wr_rd, wr_data,
    input  awr_en, awr_rd, awr_data,
    input  pending_mask
  );

endinterface

// File: rtl/regfile_wb_arbiter_port_grant.sv
// Greedy allocator of the normal and atomic regfile write ports.
// Latency: purely combinational (grants in the same cycle as requests).
// Backpressure: losers get ready=0 and must hold; rd==0 is always accepted and dropped.
module wb_port_grant
  import cpu_pkg::*;
(
  input  wb_req_t [NUM_WB-1:0] req_i,
  input  logic                 prefer_lsu_i,
  output logic [NUM_WB-1:0]    ready_o,
  output logic [NUM_WB-1:0]    norm_grant_o,
  output logic [NUM_WB-1:0]    atom_grant_o
);

  wb_idx_t       order [NUM_WB];
  wb_idx_t       idx;
  logic          norm_used;
  logic          atom_used;
  logic [AW-1:0] norm_rd;
  logic [AW-1:0] atom_rd;
  logic          clash;

  // Walk candidates AMO, preferred, other; each takes the first free eligible
  // port unless its rd already owns a port this cycle.
  always_comb begin
    ready_o      = '0;
    norm_grant_o = '0;
    atom_grant_o = '0;
    norm_used    = 1'b0;
    atom_used    = 1'b0;
    norm_rd      = '0;
    atom_rd      = '0;
    clash        = 1'b0;
    idx          = WB_ALU;
    order[0]     = WB_AMO;
    order[1]     = prefer_lsu_i ? WB_LSU : WB_ALU;
    order[2]     = prefer_lsu_i ? WB_ALU : WB_LSU;

    for (int k = 0; k < NUM_WB; k++) begin
      idx = order[k];
      if (req_i[idx].valid) begin
        if (req_i[idx].rd == '0) begin
          // Writes to x0 are discarded without touching a port.
          ready_o[idx] = 1'b1;
        end else begin
          clash = (norm_used && (norm_rd == req_i[idx].rd)) ||
                  (atom_used && (atom_rd == req_i[idx].rd));
          if (!clash) begin
            if ((idx != WB_AMO) && !norm_used) begin
              norm_grant_o[idx] = 1'b1;
              ready_o[idx]      = 1'b1;
              norm_used         = 1'b1;
              norm_rd           = req_i[idx].rd;
            end else if (!atom_used) begin
              atom_grant_o[idx] = 1'b1;
              ready_o[idx]      = 1'b1;
              atom_used         = 1'b1;
              atom_rd           = req_i[idx].rd;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: up to two regfile writes per cycle from ALU, LSU and AMO.
// Latency: handshake in cycle N, registered write ports drive the regfile in N+1.
// Backpressure: combinational ready per producer; no queue, ungranted producers retry.
module regfile_wb_arbiter
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb
);

  wb_req_t [NUM_WB-1:0] req;
  logic [NUM_WB-1:0]    ready;
  logic [NUM_WB-1:0]    norm_grant;
  logic [NUM_WB-1:0]    atom_grant;

  logic                 prefer_lsu_q, prefer_lsu_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_rd_q, wr_rd_d;
  logic [XLEN-1:0]      wr_data_q, wr_data_d;
  logic                 awr_en_q, awr_en_d;
  logic [AW-1:0]        awr_rd_q, awr_rd_d;
  logic [XLEN-1:0]      awr_data_q, awr_data_d;

  logic                 alu_granted;
  logic                 lsu_granted;
  logic                 both_nonzero;

  // Collect requests; masking valid with reset keeps every ready low in reset.
  always_comb begin
    req              = '0;
    req[WB_ALU]      = '{valid: wb.alu_valid & reset, rd: wb.alu_rd, data: wb.alu_data};
    req[WB_LSU]      = '{valid: wb.lsu_valid & reset, rd: wb.lsu_rd, data: wb.lsu_data};
    req[WB_AMO]      = '{valid: wb.amo_valid & reset, rd: wb.amo_rd, data: wb.amo_data};
  end

  wb_port_grant u_grant (
    .req_i        (req),
    .prefer_lsu_i (prefer_lsu_q),
    .ready_o      (ready),
    .norm_grant_o (norm_grant),
    .atom_grant_o (atom_grant)
  );

  assign wb.alu_ready = ready[WB_ALU];
  assign wb.lsu_ready = ready[WB_LSU];
  assign wb.amo_ready = ready[WB_AMO];

  // Port next-state: enables follow grants, rd/data only reload on a grant.
  always_comb begin
    wr_en_d    = |norm_grant;
    wr_rd_d    = wr_rd_q;
    wr_data_d  = wr_data_q;
    awr_en_d   = |atom_grant;
    awr_rd_d   = awr_rd_q;
    awr_data_d = awr_data_q;
    for (int i = 0; i < NUM_WB; i++) begin
      if (norm_grant[i]) begin
        wr_rd_d   = req[i].rd;
        wr_data_d = req[i].data;
      end
      if (atom_grant[i]) begin
        awr_rd_d   = req[i].rd;
        awr_data_d = req[i].data;
      end
    end
  end

  assign alu_granted  = norm_grant[WB_ALU] | atom_grant[WB_ALU];
  assign lsu_granted  = norm_grant[WB_LSU] | atom_grant[WB_LSU];
  assign both_nonzero = req[WB_ALU].valid && (req[WB_ALU].rd != '0) &&
                        req[WB_LSU].valid && (req[WB_LSU].rd != '0);

  // ALU/LSU fairness: favour whoever lost, alternate when both won.
  always_comb begin
    prefer_lsu_d = prefer_lsu_q;
    if (both_nonzero) begin
      if (alu_granted && lsu_granted) prefer_lsu_d = ~prefer_lsu_q;
      else if (alu_granted)           prefer_lsu_d = 1'b1;
      else if (lsu_granted)           prefer_lsu_d = 1'b0;
    end
  end

  // Output registers and the priority flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prefer_lsu_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_rd_q      <= '0;
      wr_data_q    <= '0;
      awr_en_q     <= 1'b0;
      awr_rd_q     <= '0;
      awr_data_q   <= '0;
    end else begin
      prefer_lsu_q <= prefer_lsu_d;
      wr_en_q      <= wr_en_d;
      wr_rd_q      <= wr_rd_d;
      wr_data_q    <= wr_data_d;
      awr_en_q     <= awr_en_d;
      awr_rd_q     <= awr_rd_d;
      awr_data_q   <= awr_data_d;
    end
  end

  assign wb.wr_en        = wr_en_q;
  assign wb.wr_rd        = wr_rd_q;
  assign wb.wr_data      = wr_data_q;
  assign wb.awr_en       = awr_en_q;
  assign wb.awr_rd       = awr_rd_q;
  assign wb.awr_data     = awr_data_q;
  assign wb.pending_mask = rd_onehot(wr_en_q, wr_rd_q) | rd_onehot(awr_en_q, awr_rd_q);

  // The regfile drops same-rd dual writes; the allocator must never produce one.
  a_no_dual_same_rd: assert property (@(posedge clk) disable iff (!reset)
    (wr_en_q && awr_en_q) |-> (wr_rd_q != awr_rd_q));

endmodule
